// File: rtl/module_timer_if.sv
// ----------------------------------------------------------------------------
// module_timer_if
//
// Groups the configuration and status signals between the bus-mapped timer
// registers (master) and the timer core (slave).
//
// Signals:
//   en, mode, one_shot, prescale, max, cmp, load, load_val : master -> slave
//   val, top, period_pulse, pwm, dir, running              : slave -> master
// ----------------------------------------------------------------------------
interface module_timer_if #(
    parameter int COUNTER_WIDTH   = 16,
    parameter int PRESCALER_WIDTH = 8
) ();

    logic                       en;
    logic [1:0]                 mode;
    logic                       one_shot;
    logic [PRESCALER_WIDTH-1:0] prescale;
    logic [COUNTER_WIDTH-1:0]   max;
    logic [COUNTER_WIDTH-1:0]   cmp;
    logic                       load;
    logic [COUNTER_WIDTH-1:0]   load_val;

    logic [COUNTER_WIDTH-1:0]   val;
    logic                       top;
    logic                       period_pulse;
    logic                       pwm;
    logic                       dir;
    logic                       running;

    modport master (
        output en, mode, one_shot, prescale, max, cmp, load, load_val,
        input  val, top, period_pulse, pwm, dir, running
    );

    modport slave (
        input  en, mode, one_shot, prescale, max, cmp, load, load_val,
        output val, top, period_pulse, pwm, dir, running
    );

endinterface

// File: rtl/module_timer.sv
// ----------------------------------------------------------------------------
// module_timer
//
// General-purpose timer core: prescaler, up / down / up-down counting,
// one-shot stop, synchronous load and compare (PWM) output.
//
// Ports:
//   clk            system clock, all state on rising edge
//   reset          asynchronous, active-high reset
//   bus (slave)    configuration in, status out (see module_timer_if)
//
// Optional build macro TIMER_CAPTURE_EN adds:
//   capture        asynchronous capture request (2-FF synchronised)
//   capture_val    val latched on the synchronised rising edge of capture
//   capture_valid  one-clk pulse, 3 clk after the capture input edge
// ----------------------------------------------------------------------------
module module_timer #(
    parameter int COUNTER_WIDTH   = 16,
    parameter int PRESCALER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    module_timer_if.slave            bus
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic                     capture,
    output logic [COUNTER_WIDTH-1:0] capture_val,
    output logic                     capture_valid
`endif
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_UPDOWN = 2'b10,
        MODE_UP_ALT = 2'b11
    } mode_e;

    localparam logic [COUNTER_WIDTH-1:0]   CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [PRESCALER_WIDTH-1:0] PRE_ONE = PRESCALER_WIDTH'(1);

    mode_e                      mode;
    logic [COUNTER_WIDTH-1:0]   val_q, val_d;
    logic [PRESCALER_WIDTH-1:0] presc_q, presc_d;
    logic                       dir_q, dir_d;
    logic                       running_q, running_d;
    logic                       pulse_q, pulse_d;

    logic                       enabled;
    logic                       tick;
    logic [COUNTER_WIDTH-1:0]   cnt_next;
    logic                       dir_next;
    logic [COUNTER_WIDTH-1:0]   term;

    assign mode    = mode_e'(bus.mode);
    assign enabled = bus.en & running_q;
    // Equality only: a prescale lowered below the running count lets the
    // prescaler wrap through zero instead of ticking early.
    assign tick    = enabled & (presc_q == bus.prescale);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        val_d     = val_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        running_d = running_q;
        pulse_d   = 1'b0;
        cnt_next  = val_q;
        dir_next  = dir_q;
        term      = bus.max;

        // Candidate count value for a tick, and the terminal value per mode.
        case (mode)
            MODE_DOWN: begin
                term     = '0;
                cnt_next = (val_q == '0) ? bus.max : val_q - CNT_ONE;
            end
            MODE_UPDOWN: begin
                term = '0;
                if (dir_q) begin
                    // val at or above max (max=0, or max lowered) turns round
                    // at max instead of climbing further.
                    if (val_q >= bus.max) begin
                        cnt_next = bus.max;
                        dir_next = 1'b0;
                    end else begin
                        cnt_next = val_q + CNT_ONE;
                        dir_next = (cnt_next != bus.max);
                    end
                end else begin
                    if (val_q == '0) begin
                        cnt_next = '0;
                        dir_next = 1'b1;
                    end else begin
                        cnt_next = val_q - CNT_ONE;
                        dir_next = (cnt_next == '0);
                    end
                end
            end
            default: begin
                term     = bus.max;
                cnt_next = (val_q >= bus.max) ? '0 : val_q + CNT_ONE;
            end
        endcase

        if (bus.load) begin
            // Load wins over a same-cycle tick and never pulses.
            val_d     = bus.load_val;
            presc_d   = '0;
            running_d = 1'b1;
            dir_d     = (mode != MODE_DOWN);
        end else begin
            if (enabled) begin
                presc_d = tick ? '0 : presc_q + PRE_ONE;
            end
            if (tick) begin
                if (bus.one_shot && (val_q == term)) begin
                    // Already parked on the terminal value: stop silently.
                    running_d = 1'b0;
                end else begin
                    val_d   = cnt_next;
                    dir_d   = dir_next;
                    pulse_d = (cnt_next == term);
                    if (bus.one_shot && (cnt_next == term)) begin
                        running_d = 1'b0;
                    end
                end
            end
        end

        // Fixed-direction modes override dir on every clock.
        if (mode == MODE_DOWN) begin
            dir_d = 1'b0;
        end else if (mode != MODE_UPDOWN) begin
            dir_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q     <= '0;
            presc_q   <= '0;
            dir_q     <= 1'b1;
            running_q <= 1'b1;
            pulse_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            val_q     <= val_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            pulse_q   <= pulse_d;
        end
    end

    assign bus.val          = val_q;
    assign bus.top          = (val_q == bus.max);
    assign bus.period_pulse = pulse_q;
    assign bus.pwm          = (val_q < bus.cmp);
    assign bus.dir          = dir_q;
    assign bus.running      = running_q;

`ifdef TIMER_CAPTURE_EN
    logic cap_meta, cap_sync, cap_sync_d;
    logic cap_rise;

    assign cap_rise = cap_sync & ~cap_sync_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_meta      <= 1'b0;
            cap_sync      <= 1'b0;
            cap_sync_d    <= 1'b0;
            capture_valid <= 1'b0;
            capture_val   <= '0;
        end else begin
            cap_meta      <= capture;
            cap_sync      <= cap_meta;
            cap_sync_d    <= cap_sync;
            capture_valid <= cap_rise;
            if (cap_rise) begin
                capture_val <= val_q;
            end
        end
    end
`endif

endmodule
